// File: rtl/uart_fifo_ctrl_if.sv
`default_nettype none
// ==================================================================
// uart_fifo_ctrl_if : CPU-side handshakes and serial pins of the UART
// Rev 1.0
// ==================================================================
interface uart_fifo_ctrl_if #(
   parameter int RX_FIFO_DEPTH = 4
);
   localparam int CW = $clog2(RX_FIFO_DEPTH) + 1;

   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          tx_busy;
   logic          tx;
   logic          rx;
   logic [7:0]    rx_data;
   logic          rx_perr;
   logic          rx_ferr;
   logic          rx_valid;
   logic          rx_ready;
   logic [CW-1:0] rx_count;
   logic          rx_overrun;
   logic          err_clear;
   logic          cts_n;
   logic          rts_n;

   modport master (
      output tx_data, tx_valid, rx, rx_ready, err_clear, cts_n,
      input  tx_ready, tx_busy, tx, rx_data, rx_perr, rx_ferr, rx_valid,
             rx_count, rx_overrun, rts_n
   );

   modport slave (
      input  tx_data, tx_valid, rx, rx_ready, err_clear, cts_n,
      output tx_ready, tx_busy, tx, rx_data, rx_perr, rx_ferr, rx_valid,
             rx_count, rx_overrun, rts_n
   );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ==================================================================
// uart_fifo_ctrl : parametrised UART transceiver with FWFT receive FIFO.
// Optional macro UART_FLOW_CTRL_EN enables cts_n/rts_n flow control. Rev 1.0
// ==================================================================
module uart_fifo_ctrl #(
   parameter int CLK_DIV       = 1250,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   uart_fifo_ctrl_if.slave  bus
);
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [12:0]   c_bit_last  = 13'(CLK_DIV - 1);
   localparam logic [12:0]   c_half_last = 13'(CLK_DIV / 2 - 1);
   localparam logic [12:0]   c_stop_last = 13'(STOP_BITS * CLK_DIV - 1);
   localparam logic [2:0]    c_data_last = 3'(DATA_BITS - 1);
   localparam logic [7:0]    c_data_mask = 8'((1 << DATA_BITS) - 1);
   localparam logic          c_odd       = (PARITY == 2);
   localparam logic [CW-1:0] c_depth     = CW'(RX_FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   // ---------------- transmitter ----------------
   state_e      tx_state_q, tx_state_d;
   logic [12:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_par_q, tx_par_d;
   logic        w_tx_line;
   logic        w_tx_ready;

`ifdef UART_FLOW_CTRL_EN
   assign w_tx_ready = (tx_state_q == S_IDLE) && !bus.cts_n;
`else
   logic w_unused_cts;
   assign w_unused_cts = bus.cts_n;
   assign w_tx_ready   = (tx_state_q == S_IDLE);
`endif

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      w_tx_line  = 1'b1;
      case (tx_state_q)
         S_IDLE: begin
            if (bus.tx_valid && w_tx_ready) begin
               tx_shift_d = bus.tx_data & c_data_mask;
               tx_par_d   = (^(bus.tx_data & c_data_mask)) ^ c_odd;
               tx_cnt_d   = '0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            w_tx_line = 1'b0;
            if (tx_cnt_q == c_bit_last) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = S_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 13'd1;
            end
         end
         S_DATA: begin
            w_tx_line = tx_shift_q[0];
            if (tx_cnt_q == c_bit_last) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == c_data_last) begin
                  tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 13'd1;
            end
         end
         S_PARITY: begin
            w_tx_line = tx_par_q;
            if (tx_cnt_q == c_bit_last) begin
               tx_cnt_d   = '0;
               tx_state_d = S_STOP;
            end else begin
               tx_cnt_d = tx_cnt_q + 13'd1;
            end
         end
         S_STOP: begin
            // one continuous stop interval covers both stop bits
            if (tx_cnt_q == c_stop_last) begin
               tx_cnt_d   = '0;
               tx_state_d = S_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + 13'd1;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
      end
   end

   assign bus.tx       = w_tx_line;
   assign bus.tx_ready = w_tx_ready;
   assign bus.tx_busy  = (tx_state_q != S_IDLE);

   // ---------------- receiver ----------------
   logic        rx_s1_q, rx_s2_q;
   state_e      rx_state_q, rx_state_d;
   logic [12:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_perr_q, rx_perr_d;
   logic        w_push;
   logic        w_ferr;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_perr_d  = rx_perr_q;
      w_push     = 1'b0;
      w_ferr     = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (!rx_s2_q) begin
               rx_cnt_d   = '0;
               rx_shift_d = '0;
               rx_perr_d  = 1'b0;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_cnt_q == c_half_last) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 13'd1;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == c_bit_last) begin
               rx_cnt_d             = '0;
               rx_shift_d[rx_bit_q] = rx_s2_q;
               if (rx_bit_q == c_data_last) begin
                  rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 13'd1;
            end
         end
         S_PARITY: begin
            if (rx_cnt_q == c_bit_last) begin
               rx_cnt_d   = '0;
               rx_perr_d  = rx_s2_q ^ (^rx_shift_q) ^ c_odd;
               rx_state_d = S_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q + 13'd1;
            end
         end
         S_STOP: begin
            // leave immediately after the first stop sample to catch the next start edge
            if (rx_cnt_q == c_bit_last) begin
               rx_cnt_d   = '0;
               w_ferr     = !rx_s2_q;
               w_push     = 1'b1;
               rx_state_d = S_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + 13'd1;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_perr_q  <= 1'b0;
      end else begin
         rx_s1_q    <= bus.rx;
         rx_s2_q    <= rx_s1_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_perr_q  <= rx_perr_d;
      end
   end

   // ---------------- receive FIFO ----------------
   logic [9:0]    mem_q [RX_FIFO_DEPTH];
   logic [9:0]    mem_d [RX_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] rx_count_q, rx_count_d;
   logic          rx_overrun_q, rx_overrun_d;
   logic          w_pop;
   logic          w_full;
   logic          w_push_ok;
   logic [9:0]    w_head;

   assign w_full    = (rx_count_q == c_depth);
   assign w_pop     = (rx_count_q != '0) && bus.rx_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_head    = mem_q[rd_ptr_q];

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rx_count_d   = rx_count_q;
      rx_overrun_d = rx_overrun_q;
      if (w_push_ok) begin
         mem_d[wr_ptr_q] = {w_ferr, rx_perr_q, rx_shift_q};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push_ok, w_pop})
         2'b10:   rx_count_d = rx_count_q + 1'b1;
         2'b01:   rx_count_d = rx_count_q - 1'b1;
         default: rx_count_d = rx_count_q;
      endcase
      if (w_push && !w_push_ok) begin
         rx_overrun_d = 1'b1;
      end else if (bus.err_clear) begin
         rx_overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rx_count_q   <= '0;
         rx_overrun_q <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rx_count_q   <= rx_count_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   assign bus.rx_data    = w_head[7:0];
   assign bus.rx_perr    = w_head[8];
   assign bus.rx_ferr    = w_head[9];
   assign bus.rx_valid   = (rx_count_q != '0);
   assign bus.rx_count   = rx_count_q;
   assign bus.rx_overrun = rx_overrun_q;

`ifdef UART_FLOW_CTRL_EN
   localparam logic [CW-1:0] c_rts_level = CW'(RX_FIFO_DEPTH - 1);
   logic rts_n_q, rts_n_d;

   assign rts_n_d = (rx_count_q >= c_rts_level);

   always_ff @(posedge clk) begin
      if (rst) begin
         rts_n_q <= 1'b0;
      end else begin
         rts_n_q <= rts_n_d;
      end
   end

   assign bus.rts_n = rts_n_q;
`else
   assign bus.rts_n = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ==================================================================
// tb_uart_fifo_ctrl : scoreboard bench for uart_fifo_ctrl (CLK_DIV=16, even parity)
// Rev 1.0
// ==================================================================
module tb_uart_fifo_ctrl;
   localparam int CLK_DIV   = 16;
   localparam int DATA_BITS = 8;
   localparam int PARITY    = 1;
   localparam int STOP_BITS = 1;
   localparam int DEPTH     = 4;
   localparam int FRAME     = (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS) * CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic loop_en = 1'b0;
   logic rx_drv = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   logic [9:0] exp_q[$];

   uart_fifo_ctrl_if #(.RX_FIFO_DEPTH(DEPTH)) bus();

   assign bus.rx = loop_en ? bus.tx : rx_drv;

   uart_fifo_ctrl #(
      .CLK_DIV(CLK_DIV),
      .DATA_BITS(DATA_BITS),
      .PARITY(PARITY),
      .STOP_BITS(STOP_BITS),
      .RX_FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired simulation time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic par_bit(input logic [7:0] d);
      return (^d) ^ (PARITY == 2);
   endfunction

   task automatic send_byte(input logic [7:0] d);
      int t = 0;
      @(negedge clk);
      while (!bus.tx_ready && t < 4 * FRAME) begin
         @(negedge clk);
         t++;
      end
      if (!bus.tx_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout tx_ready=%b required 1", bus.tx_ready);
      end
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
   endtask

   task automatic drive_rx_frame(input logic [7:0] d, input logic flip_par, input logic stop_val);
      logic [10:0] bits;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
      bits[9]  = par_bit(d) ^ flip_par;
      bits[10] = stop_val;
      for (int b = 0; b < 11; b++) begin
         @(negedge clk);
         rx_drv = bits[b];
         repeat (CLK_DIV - 1) @(negedge clk);
      end
      @(negedge clk);
      rx_drv = 1'b1;
   endtask

   task automatic wait_count(input int n, input int budget);
      int t = 0;
      @(negedge clk);
      while (int'(bus.rx_count) != n && t < budget) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (int'(bus.rx_count) != n) begin
         n_fail++;
         $display("FAIL wait_count rx_count=%0d required %0d", bus.rx_count, n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.tx, bus.tx_ready, bus.tx_busy, bus.rx_valid} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_tx tx/ready/busy/rx_valid=%b required 1100",
                  {bus.tx, bus.tx_ready, bus.tx_busy, bus.rx_valid});
      end
      n_checks++;
      if ({bus.rx_count, bus.rx_data, bus.rx_perr, bus.rx_ferr, bus.rx_overrun, bus.rts_n} !== '0) begin
         n_fail++;
         $display("FAIL reset_rx count=%0d data=%h perr=%b ferr=%b ovr=%b rts_n=%b required all 0",
                  bus.rx_count, bus.rx_data, bus.rx_perr, bus.rx_ferr, bus.rx_overrun, bus.rts_n);
      end
      rst = 1'b0;
   endtask

   task automatic test_tx_frame;
      logic [10:0] bits;
      logic [7:0]  d = 8'hA5;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
      bits[9]  = par_bit(d);
      bits[10] = 1'b1;
      @(negedge clk);
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus.tx !== bits[k / CLK_DIV]) begin
            n_fail++;
            $display("FAIL tx_bit clk=%0d tx=%b required %b", k, bus.tx, bits[k / CLK_DIV]);
         end
         n_checks++;
         if (bus.tx_ready !== 1'b0 || bus.tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_low clk=%0d ready=%b busy=%b required 0 1", k, bus.tx_ready, bus.tx_busy);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({bus.tx, bus.tx_ready, bus.tx_busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL tx_end tx/ready/busy=%b required 110", {bus.tx, bus.tx_ready, bus.tx_busy});
      end
   endtask

   task automatic test_reset_mid_frame;
      send_byte(8'hF0);
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.tx, bus.tx_ready, bus.tx_busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_mid_frame tx/ready/busy=%b required 110", {bus.tx, bus.tx_ready, bus.tx_busy});
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] vals[3] = '{8'h3C, 8'h00, 8'hFF};
      logic [9:0] e;
      loop_en      = 1'b1;
      bus.rx_ready = 1'b0;
      foreach (vals[i]) begin
         send_byte(vals[i]);
         exp_q.push_back({2'b00, vals[i]});
      end
      wait_count(3, 4 * FRAME);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if ({bus.rx_valid, bus.rx_ferr, bus.rx_perr, bus.rx_data} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL b2b_pop got v=%b f=%b p=%b d=%h required v=1 f=%b p=%b d=%h",
                     bus.rx_valid, bus.rx_ferr, bus.rx_perr, bus.rx_data, e[9], e[8], e[7:0]);
         end
         bus.rx_ready = 1'b1;
         @(posedge clk);
         #1 bus.rx_ready = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (bus.rx_valid !== 1'b0 || bus.rx_count !== '0) begin
         n_fail++;
         $display("FAIL b2b_empty valid=%b count=%0d required 0 0", bus.rx_valid, bus.rx_count);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_rx_errors;
      logic [9:0] e;
      drive_rx_frame(8'h55, 1'b0, 1'b0);
      exp_q.push_back({1'b1, 1'b0, 8'h55});
      repeat (2 * CLK_DIV) @(negedge clk);
      drive_rx_frame(8'h5A, 1'b1, 1'b1);
      exp_q.push_back({1'b0, 1'b1, 8'h5A});
      wait_count(2, 2 * FRAME);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if ({bus.rx_valid, bus.rx_ferr, bus.rx_perr, bus.rx_data} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL err_pop got v=%b f=%b p=%b d=%h required v=1 f=%b p=%b d=%h",
                     bus.rx_valid, bus.rx_ferr, bus.rx_perr, bus.rx_data, e[9], e[8], e[7:0]);
         end
         bus.rx_ready = 1'b1;
         @(posedge clk);
         #1 bus.rx_ready = 1'b0;
      end
   endtask

   task automatic test_glitch;
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3 * CLK_DIV) @(negedge clk);
      n_checks++;
      if (bus.rx_count !== '0 || bus.rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch count=%0d valid=%b required 0 0", bus.rx_count, bus.rx_valid);
      end
   endtask

   task automatic test_overrun;
      logic [7:0] vals[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [9:0] e;
      loop_en      = 1'b1;
      bus.rx_ready = 1'b0;
      foreach (vals[i]) begin
         send_byte(vals[i]);
         if (exp_q.size() < DEPTH) exp_q.push_back({2'b00, vals[i]});
      end
      repeat (FRAME + 2 * CLK_DIV) @(negedge clk);
      n_checks++;
      if (int'(bus.rx_count) != DEPTH || bus.rx_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_full count=%0d ovr=%b required %0d 1", bus.rx_count, bus.rx_overrun, DEPTH);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if ({bus.rx_valid, bus.rx_ferr, bus.rx_perr, bus.rx_data} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL overrun_pop got v=%b f=%b p=%b d=%h required v=1 f=%b p=%b d=%h",
                     bus.rx_valid, bus.rx_ferr, bus.rx_perr, bus.rx_data, e[9], e[8], e[7:0]);
         end
         bus.rx_ready = 1'b1;
         @(posedge clk);
         #1 bus.rx_ready = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (bus.rx_overrun !== 1'b1 || bus.rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_sticky ovr=%b valid=%b required 1 0", bus.rx_overrun, bus.rx_valid);
      end
      bus.err_clear = 1'b1;
      @(posedge clk);
      #1 bus.err_clear = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear ovr=%b required 0", bus.rx_overrun);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_flow_ctrl;
      logic [9:0] e;
`ifdef UART_FLOW_CTRL_EN
      @(negedge clk);
      bus.cts_n    = 1'b1;
      bus.tx_data  = 8'h81;
      bus.tx_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         n_checks++;
         if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cts_block tx=%b ready=%b required 1 0", bus.tx, bus.tx_ready);
         end
      end
      bus.cts_n = 1'b0;
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.tx !== 1'b0) begin
         n_fail++;
         $display("FAIL cts_start tx=%b required 0", bus.tx);
      end
      repeat (FRAME) @(negedge clk);
      loop_en      = 1'b1;
      bus.rx_ready = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         send_byte(8'(8'h60 + i));
         exp_q.push_back({2'b00, 8'(8'h60 + i)});
      end
      wait_count(DEPTH - 1, 4 * FRAME);
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.rts_n !== 1'b1) begin
         n_fail++;
         $display("FAIL rts_assert rts_n=%b required 1", bus.rts_n);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if ({bus.rx_valid, bus.rx_ferr, bus.rx_perr, bus.rx_data} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL flow_pop got v=%b f=%b p=%b d=%h required v=1 f=%b p=%b d=%h",
                     bus.rx_valid, bus.rx_ferr, bus.rx_perr, bus.rx_data, e[9], e[8], e[7:0]);
         end
         bus.rx_ready = 1'b1;
         @(posedge clk);
         #1 bus.rx_ready = 1'b0;
         if (exp_q.size() == DEPTH - 2) begin
            repeat (2) @(negedge clk);
            n_checks++;
            if (bus.rts_n !== 1'b0) begin
               n_fail++;
               $display("FAIL rts_release rts_n=%b required 0", bus.rts_n);
            end
         end
      end
      loop_en = 1'b0;
`else
      @(negedge clk);
      bus.cts_n = 1'b1;
      n_checks++;
      if (bus.tx_ready !== 1'b1 || bus.rts_n !== 1'b0) begin
         n_fail++;
         $display("FAIL cts_ignored ready=%b rts_n=%b required 1 0", bus.tx_ready, bus.rts_n);
      end
      bus.tx_data  = 8'h81;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.tx !== 1'b0) begin
         n_fail++;
         $display("FAIL cts_ignored_start tx=%b required 0", bus.tx);
      end
      repeat (FRAME) @(negedge clk);
      bus.cts_n = 1'b0;
      e = '0;
      exp_q.delete();
`endif
   endtask

   initial begin
      bus.tx_data   = '0;
      bus.tx_valid  = 1'b0;
      bus.rx_ready  = 1'b0;
      bus.err_clear = 1'b0;
      bus.cts_n     = 1'b0;
      test_reset();
      test_tx_frame();
      test_reset_mid_frame();
      test_back_to_back();
      test_rx_errors();
      test_glitch();
      test_overrun();
      test_flow_ctrl();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
